// File: rtl/parity_tx_pkg.sv
// Shared types and line levels for the two-requester parity serial transmitter.
package parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int   FRAME_BITS = 11;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam logic IDLE_LVL   = 1'b1;

endpackage

// File: rtl/parity_tx_arb_if.sv
// Requester handshakes plus serial line status, bundled between producers and the transmitter.
interface parity_tx_arb_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_src;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, tx_out, tx_busy, tx_done, tx_src
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, tx_out, tx_busy, tx_done, tx_src
  );
endinterface

// File: rtl/even_parity_gen.sv
// Appends the even-parity bit to a byte; output is {data, parity}.
module even_parity_gen (
  input  logic [7:0] data,
  output logic [8:0] coded
);
  assign coded = {data, ^data};
endmodule

// File: rtl/parity_tx_arb.sv
// Round-robin arbiter feeding one even-parity encoder and a start/8-data/parity/stop serializer.
//
// state  | meaning
// IDLE   | line high, offering ready to the granted requester
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | data bits LSB-first, bit_cnt selects the bit
// PARITY | even-parity bit of the latched byte
// STOP   | stop bit (high); tx_done on its final cycle
module parity_tx_arb
  import parity_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  parity_tx_arb_if.slave  bus
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_W - 1);

  tx_state_e         state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W:0]   frame_q;
  logic              last_grant;
  logic              tx_out_q;
  logic              busy_q;
  logic              done_q;
  logic              src_q;

  logic              grant;
  logic              ready0;
  logic              ready1;
  logic              hs;
  logic              bit_end;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [2:0]        bit_nxt;
  logic [DATA_W-1:0] mux_data;
  logic [DATA_W:0]   coded;

  // On a tie the requester that lost last time wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign ready0 = !rst && (state == IDLE) && bus.req0_valid && !grant;
  assign ready1 = !rst && (state == IDLE) && bus.req1_valid &&  grant;
  assign hs     = ready0 || ready1;

  assign mux_data = grant ? bus.req1_data : bus.req0_data;

  even_parity_gen u_parity (
    .data  (mux_data),
    .coded (coded)
  );

  assign bit_end = (clk_cnt == CNT_LAST);
  assign cnt_nxt = clk_cnt + 1'b1;
  assign bit_nxt = bit_cnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      frame_q    <= '0;
      last_grant <= 1'b1;
      tx_out_q   <= IDLE_LVL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            // Held as {parity, data} for the whole frame.
            frame_q    <= {coded[0], coded[DATA_W:1]};
            src_q      <= grant;
            last_grant <= grant;
            tx_out_q   <= START_LVL;
            busy_q     <= 1'b1;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            tx_out_q <= frame_q[0];
            state    <= DATA;
          end else begin
            clk_cnt <= cnt_nxt;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              tx_out_q <= frame_q[DATA_W];
              state    <= PARITY;
            end else begin
              bit_cnt  <= bit_nxt;
              tx_out_q <= frame_q[{1'b0, bit_nxt}];
            end
          end else begin
            clk_cnt <= cnt_nxt;
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            tx_out_q <= STOP_LVL;
            done_q   <= (CNT_LAST == '0);
            state    <= STOP;
          end else begin
            clk_cnt <= cnt_nxt;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            tx_out_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            clk_cnt <= cnt_nxt;
            done_q  <= (cnt_nxt == CNT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.tx_out     = tx_out_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.tx_src     = src_q;

endmodule

// File: tb/tb_parity_tx_arb.sv
// Directed bench for parity_tx_arb at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_parity_tx_arb;
  import parity_tx_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  parity_tx_arb_if #(.DATA_W(8)) bus4 ();
  parity_tx_arb_if #(.DATA_W(8)) bus1 ();

  parity_tx_arb #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  parity_tx_arb #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // fr holds the line bits in transmit order, bit 0 first: {stop, parity, data[7:0], start}.
  // Entered at the falling edge of the first frame cycle; leaves at the first idle cycle.
  task automatic check_frame(input string tag, input bit which, input logic [10:0] fr,
                             input logic src);
    logic [10:0] sh;
    int          cpb;
    logic        o_tx, o_busy, o_done, o_src, o_r0, o_r1;
    sh  = fr;
    cpb = which ? 1 : 4;
    for (int i = 0; i < FRAME_BITS; i++) begin
      for (int c = 0; c < cpb; c++) begin
        #1;
        o_tx   = which ? bus1.tx_out     : bus4.tx_out;
        o_busy = which ? bus1.tx_busy    : bus4.tx_busy;
        o_done = which ? bus1.tx_done    : bus4.tx_done;
        o_src  = which ? bus1.tx_src     : bus4.tx_src;
        o_r0   = which ? bus1.req0_ready : bus4.req0_ready;
        o_r1   = which ? bus1.req1_ready : bus4.req1_ready;
        chk($sformatf("%s_bit%0d_c%0d_tx", tag, i, c), o_tx, sh[0]);
        chk($sformatf("%s_bit%0d_c%0d_busy", tag, i, c), o_busy, 1'b1);
        chk($sformatf("%s_bit%0d_c%0d_done", tag, i, c), o_done,
            (i == FRAME_BITS - 1) && (c == cpb - 1));
        chk($sformatf("%s_bit%0d_c%0d_src", tag, i, c), o_src, src);
        chk($sformatf("%s_bit%0d_c%0d_rdy0", tag, i, c), o_r0, 1'b0);
        chk($sformatf("%s_bit%0d_c%0d_rdy1", tag, i, c), o_r1, 1'b0);
        @(negedge clk);
      end
      sh = sh >> 1;
    end
    #1;
    o_tx   = which ? bus1.tx_out  : bus4.tx_out;
    o_busy = which ? bus1.tx_busy : bus4.tx_busy;
    o_done = which ? bus1.tx_done : bus4.tx_done;
    chk({tag, "_idle_tx"},   o_tx,   1'b1);
    chk({tag, "_idle_busy"}, o_busy, 1'b0);
    chk({tag, "_idle_done"}, o_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus4.req0_valid = 1'b0; bus4.req0_data = 8'h00;
    bus4.req1_valid = 1'b0; bus4.req1_data = 8'h00;
    bus1.req0_valid = 1'b0; bus1.req0_data = 8'h00;
    bus1.req1_valid = 1'b0; bus1.req1_data = 8'h00;
    #1 rst = 1'b1;

    // Reset state, ready held low even with a valid request.
    @(negedge clk);
    @(negedge clk);
    bus4.req0_valid = 1'b1;
    #1;
    chk("rst_tx",   bus4.tx_out,     1'b1);
    chk("rst_busy", bus4.tx_busy,    1'b0);
    chk("rst_done", bus4.tx_done,    1'b0);
    chk("rst_src",  bus4.tx_src,     1'b0);
    chk("rst_rdy0", bus4.req0_ready, 1'b0);
    chk("rst_rdy1", bus4.req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus4.req0_valid = 1'b0;

    // req0 sends 0xA5: parity 0.
    @(negedge clk);
    bus4.req0_valid = 1'b1; bus4.req0_data = 8'hA5;
    #1;
    chk("a5_rdy0", bus4.req0_ready, 1'b1);
    chk("a5_rdy1", bus4.req1_ready, 1'b0);
    @(negedge clk);
    bus4.req0_valid = 1'b0;
    check_frame("a5", 1'b0, 11'b1_0_10100101_0, 1'b0);

    // req1 sends 0x07: parity 1.
    bus4.req1_valid = 1'b1; bus4.req1_data = 8'h07;
    #1;
    chk("07_rdy1", bus4.req1_ready, 1'b1);
    chk("07_rdy0", bus4.req0_ready, 1'b0);
    @(negedge clk);
    bus4.req1_valid = 1'b0;
    check_frame("07", 1'b0, 11'b1_1_00000111_0, 1'b1);

    // Both valid continuously: 0,1,0,1 with one idle cycle between frames.
    bus4.req0_valid = 1'b1; bus4.req0_data = 8'h11;
    bus4.req1_valid = 1'b1; bus4.req1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_rdy0", k), bus4.req0_ready, (k % 2) == 0);
      chk($sformatf("rr%0d_rdy1", k), bus4.req1_ready, (k % 2) == 1);
      @(negedge clk);
      if ((k % 2) == 0) check_frame($sformatf("rr%0d", k), 1'b0, 11'b1_0_00010001_0, 1'b0);
      else              check_frame($sformatf("rr%0d", k), 1'b0, 11'b1_0_00100010_0, 1'b1);
    end
    bus4.req0_valid = 1'b0;
    bus4.req1_valid = 1'b0;

    // 0x3C latched; requester data changes to 0xFF during the frame.
    @(negedge clk);
    bus4.req0_valid = 1'b1; bus4.req0_data = 8'h3C;
    #1;
    chk("3c_rdy0", bus4.req0_ready, 1'b1);
    @(negedge clk);
    bus4.req0_valid = 1'b0; bus4.req0_data = 8'hFF;
    check_frame("3c", 1'b0, 11'b1_0_00111100_0, 1'b0);

    // Reset during data bit 3 of 0xA5 (bit value 0).
    @(negedge clk);
    bus4.req0_valid = 1'b1; bus4.req0_data = 8'hA5;
    @(negedge clk);
    bus4.req0_valid = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    chk("mid_pre_tx",   bus4.tx_out,  1'b0);
    chk("mid_pre_busy", bus4.tx_busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx",   bus4.tx_out,  1'b1);
    chk("mid_rst_busy", bus4.tx_busy, 1'b0);
    chk("mid_rst_done", bus4.tx_done, 1'b0);
    bus4.req0_valid = 1'b1;
    #1;
    chk("mid_rst_rdy0", bus4.req0_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_rst2_done", bus4.tx_done, 1'b0);
    rst = 1'b0;
    bus4.req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_tx", k),   bus4.tx_out,  1'b1);
      chk($sformatf("post_rst%0d_busy", k), bus4.tx_busy, 1'b0);
      chk($sformatf("post_rst%0d_done", k), bus4.tx_done, 1'b0);
    end
    bus4.req0_valid = 1'b1; bus4.req0_data = 8'h11;
    bus4.req1_valid = 1'b1; bus4.req1_data = 8'h22;
    #1;
    chk("tie_rdy0", bus4.req0_ready, 1'b1);
    chk("tie_rdy1", bus4.req1_ready, 1'b0);
    @(negedge clk);
    bus4.req0_valid = 1'b0;
    bus4.req1_valid = 1'b0;
    check_frame("tie", 1'b0, 11'b1_0_00010001_0, 1'b0);

    // CLKS_PER_BIT=1, 0x80: parity 1.
    bus1.req0_valid = 1'b1; bus1.req0_data = 8'h80;
    #1;
    chk("c1_rdy0", bus1.req0_ready, 1'b1);
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    check_frame("c1_80", 1'b1, 11'b1_1_10000000_0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_tx_arb.md
# parity_tx_arb

Shares one even-parity encoder and one serial line between two byte requesters. Requesters are arbitrated round-robin. The granted byte is extended with its even-parity bit and shifted out as an 11-bit frame: start, 8 data LSB-first, parity, stop. The block sits between byte-producing logic and the board-level serial pin.

## Interface
- CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range ≥1.
- DATA_W, default 8, byte width; fixed at 8 for this revision.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  combinational; accept strobe to requester 0.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  combinational; accept strobe to requester 1.
- tx_out  out  1  registered serial line; idles high.
- tx_busy  out  1  registered; frame in progress.
- tx_done  out  1  registered; one-cycle pulse, last stop-bit cycle.
- tx_src  out  1  registered; requester index of the current or last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, tx_busy=0. readyN is high only in IDLE, only for the granted requester, and only while reqN_valid is high.
- A handshake occurs when validN & readyN are both high.
- Grant with one valid: that requester wins.
- Grant with both valid: the requester not granted last time (last_grant) wins.
- On handshake:
  - Latch shift register = {^data, data}.
  - Set tx_src = N and last_grant = N.
  - Go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx_out = data[i], i=0..7, each bit for CLKS_PER_BIT cycles, then go to PARITY.
- PARITY: tx_out = ^data (even parity: total ones over data+parity is even), then go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. tx_done=1 on the final STOP cycle, then go to IDLE.
- Counters:
  - bit_cnt counts 0..7 in DATA.
  - clk_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT)+1.
  - Both wrap to 0 at each bit boundary.
- Latched byte is held for the whole frame. Requester inputs outside the handshake cycle are ignored.
- Reset values: tx_out=1, tx_busy=0, tx_done=0, tx_src=0, req*_ready=0 while rst high, state=IDLE, last_grant=1 (so req0 wins the first tie), counters=0.
- Reset mid-frame: the frame is abandoned immediately (async). The line returns high, no tx_done is issued, and no byte is re-sent.

## Timing
- Handshake on edge T0. From cycle T0+1, tx_busy=1 and tx_out=0 (start bit).
- Frame length: 11·CLKS_PER_BIT cycles, T0+1 through T0+11·CLKS_PER_BIT.
- tx_done and the last stop cycle coincide at cycle T0+11·CLKS_PER_BIT.
- The next handshake can occur at the earliest in the following IDLE cycle. Back-to-back frame period is 11·CLKS_PER_BIT+1 cycles.
- readyN is low throughout START..STOP, including the tx_done cycle.
- Both requesters valid continuously: grants alternate 0,1,0,1…
- CLKS_PER_BIT=1: every state bit lasts exactly one cycle. There is no zero-length bit.

## Structure
- Package parity_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - FRAME_BITS=11;
  - START_LVL=0, STOP_LVL=1, IDLE_LVL=1.
- Sub-module even_parity_gen: 8-bit in, 9-bit out {data, ^data}, purely combinational. It is instantiated once and fed by the arbiter mux output.
- Top module contains the round-robin grant logic, FSM, counters and shift register.

## Test plan
- Reset then req0 sends 0xA5, CLKS_PER_BIT=4 -> line reads 0,1,0,1,0,0,1,0,1,parity 0,1, each bit 4 cycles. tx_done at T0+44; tx_src=0.
- req1 sends 0x07 -> data bits 1,1,1,0,0,0,0,0 and parity 1. req1_ready pulses once; req0_ready stays 0.
- Both valid continuously, bytes 0x11/0x22 -> frames alternate src 0,1,0,1, starting with 0. Gap between frames is exactly 1 idle cycle.
- req0 changes data to 0xFF mid-frame after sending 0x3C -> the line still carries 0x3C with parity 0.
- rst asserted during the DATA bit 3 -> tx_out=1 and tx_busy=0 immediately, with no tx_done. After release, tied requesters: req0 granted first.
- CLKS_PER_BIT=1, 0x80 -> frame 0,0,0,0,0,0,0,0,1,1,1 in 11 consecutive cycles. tx_done on the 11th cycle.
